// File: rtl/x87_memstore_seq.sv
// Store sequencer behind the x87 execution unit.
// It queues memstore requests and splits each one into dword-aligned bus write beats.
module x87_memstore_seq #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [1:0]  st_size,
    input  logic [63:0] st_data,
    input  logic [31:0] st_addr,
    output logic        st_full,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    input  logic        wr_ack,
    output logic        st_done,
    output logic        st_err
);
    // state | meaning
    // IDLE  | waiting for a queued store; pops the head and loads the first beat
    // BEAT  | wr_req held high; each ack advances to the next populated dword
    // DONE  | st_done pulse, one bubble before the next store
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    q_size [DEPTH];
    logic [63:0]   q_data [DEPTH];
    logic [31:0]   q_addr [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_next;

    state_t      state;
    logic [7:0]  mask_rem;
    logic [63:0] data_rem;

    logic        full, pop, push, bad_size, overflow;
    logic [1:0]  h_size;
    logic [63:0] h_data;
    logic [31:0] h_addr;
    logic [7:0]  mask8;
    logic [11:0] mask12;
    logic [95:0] data96;

    always_comb begin
        full       = (count == CW'(DEPTH));
        pop        = (state == IDLE) && (count != '0);
        bad_size   = st_valid && (st_size == 2'd3);
        push       = st_valid && !bad_size && (!full || pop);
        overflow   = st_valid && !bad_size && full && !pop;
        count_next = count + CW'(push) - CW'(pop);

        h_size = q_size[head];
        h_data = q_data[head];
        h_addr = q_addr[head];
        case (h_size)
            2'd0:    mask8 = 8'h03;
            2'd1:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        mask12 = {4'b0000, mask8} << h_addr[1:0];
        data96 = {32'b0, h_data} << {h_addr[1:0], 3'b000};
    end

    // Queue storage needs no reset; occupancy is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_size[tail] <= st_size;
            q_data[tail] <= st_data;
            q_addr[tail] <= st_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            st_full  <= 1'b0;
            st_err   <= 1'b0;
            state    <= IDLE;
            wr_req   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_be    <= '0;
            st_done  <= 1'b0;
            mask_rem <= '0;
            data_rem <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count   <= count_next;
            st_full <= (count_next == CW'(DEPTH));
            if (bad_size || overflow) st_err <= 1'b1;

            case (state)
                IDLE: begin
                    st_done <= 1'b0;
                    if (pop) begin
                        // The lowest dword always holds the first byte, so beat 0 is never empty.
                        wr_addr  <= {h_addr[31:2], 2'b00};
                        wr_data  <= data96[31:0];
                        wr_be    <= mask12[3:0];
                        mask_rem <= mask12[11:4];
                        data_rem <= data96[95:32];
                        wr_req   <= 1'b1;
                        state    <= BEAT;
                    end
                end
                BEAT: begin
                    if (wr_ack) begin
                        if (mask_rem[3:0] != 4'b0000) begin
                            wr_addr  <= wr_addr + 32'd4;
                            wr_data  <= data_rem[31:0];
                            wr_be    <= mask_rem[3:0];
                            mask_rem <= {4'b0000, mask_rem[7:4]};
                            data_rem <= {32'b0, data_rem[63:32]};
                        end else begin
                            wr_req  <= 1'b0;
                            st_done <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    st_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x87_memstore_seq.sv
// Directed bench for x87_memstore_seq: beat splitting, queue overflow,
// reserved size and mid-burst reset.
module tb_x87_memstore_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [1:0]  st_size;
    logic [63:0] st_data;
    logic [31:0] st_addr;
    logic        st_full;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ack;
    logic        st_done;
    logic        st_err;

    int vectors = 0;
    int miscompares = 0;

    x87_memstore_seq #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_size(st_size),
        .st_data(st_data), .st_addr(st_addr), .st_full(st_full),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ack(wr_ack), .st_done(st_done), .st_err(st_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic store(input logic [1:0] sz, input logic [63:0] d, input logic [31:0] a);
        st_valid = 1'b1;
        st_size  = sz;
        st_data  = d;
        st_addr  = a;
        tick();
        st_valid = 1'b0;
        st_size  = 2'd0;
        st_data  = '0;
        st_addr  = '0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (wr_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'b0, wr_req}, 32'd1);
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        wait_req(tag);
        chk({tag, "_addr"}, wr_addr, a);
        chk({tag, "_be"}, {28'b0, wr_be}, {28'b0, be});
        chk({tag, "_data"}, wr_data & lanes(be), d & lanes(be));
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
    endtask

    task automatic done(input string tag);
        chk({tag, "_done"}, {31'b0, st_done}, 32'd1);
        chk({tag, "_req_low"}, {31'b0, wr_req}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, st_done}, 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_full"}, {31'b0, st_full}, 32'd0);
        chk({tag, "_req"}, {31'b0, wr_req}, 32'd0);
        chk({tag, "_addr"}, wr_addr, 32'd0);
        chk({tag, "_data"}, wr_data, 32'd0);
        chk({tag, "_be"}, {28'b0, wr_be}, 32'd0);
        chk({tag, "_done"}, {31'b0, st_done}, 32'd0);
        chk({tag, "_err"}, {31'b0, st_err}, 32'd0);
    endtask

    initial begin
        int seen;
        rst      = 1'b1;
        st_valid = 1'b0;
        st_size  = 2'd0;
        st_data  = '0;
        st_addr  = '0;
        wr_ack   = 1'b0;
        repeat (2) tick();
        chk_reset_state("rst0");
        rst = 1'b0;
        tick();

        // 32-bit aligned store, one beat, first request one edge after capture
        store(2'd1, 64'h11223344, 32'h0000_1000);
        chk("t1_lat0", {31'b0, wr_req}, 32'd0);
        tick();
        chk("t1_lat1", {31'b0, wr_req}, 32'd1);
        beat("t1", 32'h0000_1000, 32'h1122_3344, 4'hF);
        done("t1");

        // 16-bit store straddling a dword boundary
        store(2'd0, 64'hABCD, 32'h0000_2003);
        beat("t2a", 32'h0000_2000, 32'hCD00_0000, 4'h8);
        chk("t2_nobubble", {31'b0, wr_req}, 32'd1);
        beat("t2b", 32'h0000_2004, 32'h0000_00AB, 4'h1);
        done("t2");

        // 64-bit unaligned store, three beats
        store(2'd2, 64'h0102_0304_0506_0708, 32'h0000_3001);
        beat("t3a", 32'h0000_3000, 32'h0607_0800, 4'hE);
        beat("t3b", 32'h0000_3004, 32'h0203_0405, 4'hF);
        beat("t3c", 32'h0000_3008, 32'h0000_0001, 4'h1);
        done("t3");
        chk("t3_err", {31'b0, st_err}, 32'd0);

        // Overflow: one store stalled in BEAT, then three back-to-back
        store(2'd1, 64'hAAAA5555, 32'h0000_4000);
        wait_req("t4p");
        store(2'd1, 64'h11111111, 32'h0000_4004);
        chk("t4_full1", {31'b0, st_full}, 32'd0);
        store(2'd1, 64'h22222222, 32'h0000_4008);
        chk("t4_full2", {31'b0, st_full}, 32'd1);
        chk("t4_err2", {31'b0, st_err}, 32'd0);
        store(2'd1, 64'h33333333, 32'h0000_400C);
        chk("t4_err3", {31'b0, st_err}, 32'd1);
        chk("t4_full3", {31'b0, st_full}, 32'd1);
        repeat (2) tick();
        chk("t4_hold_addr", wr_addr, 32'h0000_4000);
        beat("t4p", 32'h0000_4000, 32'hAAAA_5555, 4'hF);
        done("t4p");
        beat("t4s1", 32'h0000_4004, 32'h1111_1111, 4'hF);
        done("t4s1");
        beat("t4s2", 32'h0000_4008, 32'h2222_2222, 4'hF);
        done("t4s2");
        seen = 0;
        repeat (6) begin
            tick();
            if (wr_req !== 1'b0) seen++;
        end
        chk("t4_dropped", seen, 32'd0);
        chk("t4_err_sticky", {31'b0, st_err}, 32'd1);

        rst = 1'b1;
        tick();
        chk_reset_state("rst1");
        rst = 1'b0;

        // Reserved size is never queued
        store(2'd3, 64'h5A5A, 32'h0000_5000);
        chk("t5_err", {31'b0, st_err}, 32'd1);
        seen = 0;
        repeat (5) begin
            tick();
            if (wr_req !== 1'b0) seen++;
        end
        chk("t5_noreq", seen, 32'd0);

        // Reset during the second beat abandons the store
        store(2'd2, 64'h0102_0304_0506_0708, 32'h0000_3001);
        beat("t5a", 32'h0000_3000, 32'h0607_0800, 4'hE);
        chk("t5_beat2_addr", wr_addr, 32'h0000_3004);
        rst = 1'b1;
        tick();
        chk_reset_state("rst2");
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (wr_req !== 1'b0 || st_done !== 1'b0) seen++;
        end
        chk("t5_abandoned", seen, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
